ctrl_hazard_unit: RTL and testbench
===================================

CTRL_HAZARD_UNIT -- requirements
Module: ctrl_hazard_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, PC width in bits.
REQ-002 The block SHALL have parameter BHT_DEPTH, default 16, number of branch-history entries (power of 2, 4..256).
REQ-003 The block SHALL have parameter FLUSH_STAGES, default 3, number of younger pipeline registers flushed on redirect (1..4).
REQ-004 The block SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-005 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port if_pc  input  PC_W  fetch-stage PC.
REQ-008 The block SHALL have ports id_rs, id_rt  input  5 each  ID-stage source registers.
REQ-009 The block SHALL have ports ex_memread  input  1, and ex_rt  input  5  EX-stage load and its destination.
REQ-010 The block SHALL have ports mem_is_branch, mem_is_jump, mem_taken, mem_pred_taken  input  1 each, and mem_pc  input  PC_W  MEM-stage resolution.
REQ-011 The block SHALL have port pred_taken  output  1  prediction for if_pc.
REQ-012 The block SHALL have ports stall_pc, stall_ifid, bubble_idex  output  1 each  load-use stall controls.
REQ-013 The block SHALL have ports flush  output  FLUSH_STAGES  per-stage flush (bit 0 = IF/ID), and redirect, redirect_taken  output  1 each.
REQ-014 The block SHALL have ports branch_cnt, mispred_cnt  output  CNT_W each  statistics.

Function
REQ-015 The BHT SHALL hold BHT_DEPTH 2-bit saturating counters: SNT=00, WNT=01, WT=10, ST=11.
REQ-016 Read index SHALL be if_pc[log2(BHT_DEPTH)+1:2]; pred_taken SHALL equal bit 1 of that entry, combinationally, zero latency.
REQ-017 When mem_is_branch=1, the entry indexed by mem_pc[log2(BHT_DEPTH)+1:2] SHALL be updated at the next rising edge: increment if mem_taken, else decrement, saturating at ST/SNT.
REQ-018 A same-cycle read and update of one index SHALL return the pre-update value (no bypass).
REQ-019 mispredict SHALL equal mem_is_branch & (mem_taken != mem_pred_taken); redirect SHALL equal mispredict | mem_is_jump, combinationally.
REQ-020 redirect_taken SHALL be 1 for jumps or mispredicted-taken branches, and 0 for mispredicted-not-taken branches (PC returns to mem_pc+4).
REQ-021 flush SHALL be all ones while redirect=1, else all zeros.
REQ-022 A load-use hazard SHALL be ex_memread & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-023 During a load-use hazard with redirect=0, stall_pc, stall_ifid and bubble_idex SHALL be 1.
REQ-024 When redirect=1, all three stall outputs SHALL be 0 (redirect has priority).
REQ-025 branch_cnt SHALL increment on every cycle with mem_is_branch=1; mispred_cnt SHALL increment on every cycle with mispredict=1; both SHALL saturate at all ones.
REQ-026 mem_is_jump with mem_is_branch both 1 SHALL be treated as a jump for redirect_taken and as a branch for BHT and counter updates.

Reset
REQ-027 rst_n low SHALL immediately set all BHT entries to WNT and both counters to 0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard any pending update; the first update SHALL occur at the first rising edge with rst_n high.
REQ-029 Combinational outputs SHALL follow their equations during reset, with pred_taken=0.

Structure
REQ-030 A shared package hazard_pkg SHALL hold the SNT/WNT/WT/ST constants and default parameter values.
REQ-031 The BHT SHALL be a sub-module bht_2bit (parameter BHT_DEPTH; read port, update port, clk, rst_n); the hazard and redirect logic SHALL stay in ctrl_hazard_unit.

Verification
REQ-032 After reset, if_pc=0x40 -> pred_taken=0; branch_cnt=0; mispred_cnt=0.
REQ-033 Two taken updates at mem_pc=0x40 with mem_pred_taken=0 -> first update: redirect=1, flush=3'b111, redirect_taken=1; after both updates, if_pc=0x40 gives pred_taken=1 and mispred_cnt=2.
REQ-034 ex_memread=1, ex_rt=5, id_rs=5 -> stall_pc=stall_ifid=bubble_idex=1; ex_rt=0 with the same inputs -> all three stalls 0.
REQ-035 Load-use hazard plus mem_is_jump=1 in the same cycle -> stalls 0, redirect=1, redirect_taken=1, flush all ones.
REQ-036 Four consecutive taken updates at one index -> saturates at ST; then one not-taken update with mem_pred_taken=1 -> WT, redirect_taken=0, mispred_cnt increments.
REQ-037 With CNT_W=4, 20 branch cycles -> branch_cnt holds 15; rst_n pulsed low between edges -> counters read 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the control-hazard unit: predictor counter states,
// default parameter values and the 2-bit saturating update rule.
package hazard_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    localparam int DEF_PC_W         = 32;
    localparam int DEF_BHT_DEPTH    = 16;
    localparam int DEF_FLUSH_STAGES = 3;
    localparam int DEF_CNT_W        = 16;

    function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
        bht_state_e nxt;
        nxt = cur;
        unique case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port (prediction) and one registered update port, no read/update bypass.
module bht_2bit
    import hazard_pkg::*;
#(
    parameter int BHT_DEPTH = DEF_BHT_DEPTH,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_state_e r_cnt [BHT_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_cnt[i] <= WNT;
            end
        end else if (upd_en) begin
            r_cnt[upd_idx] <= bht_next(r_cnt[upd_idx], upd_taken);
        end
    end

    // Upper counter bit is the taken prediction; the read sees pre-update state.
    assign rd_taken = r_cnt[rd_idx][1];

endmodule

// File: rtl/ctrl_hazard_unit.sv
// Pipeline control: branch prediction lookup, MEM-stage redirect/flush on
// mispredict or jump, load-use stall generation and branch statistics.
module ctrl_hazard_unit
    import hazard_pkg::*;
#(
    parameter int PC_W         = DEF_PC_W,
    parameter int BHT_DEPTH    = DEF_BHT_DEPTH,
    parameter int FLUSH_STAGES = DEF_FLUSH_STAGES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PC_W-1:0]         if_pc,
    input  logic [4:0]              id_rs,
    input  logic [4:0]              id_rt,
    input  logic                    ex_memread,
    input  logic [4:0]              ex_rt,
    input  logic                    mem_is_branch,
    input  logic                    mem_is_jump,
    input  logic                    mem_taken,
    input  logic                    mem_pred_taken,
    input  logic [PC_W-1:0]         mem_pc,
    output logic                    pred_taken,
    output logic                    stall_pc,
    output logic                    stall_ifid,
    output logic                    bubble_idex,
    output logic [FLUSH_STAGES-1:0] flush,
    output logic                    redirect,
    output logic                    redirect_taken,
    output logic [CNT_W-1:0]        branch_cnt,
    output logic [CNT_W-1:0]        mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_mispredict;
    logic             w_load_use;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    // Word-aligned PCs: bits [1:0] and the bits above the index never select an entry.
    logic w_unused_pc;
    assign w_unused_pc = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                           mem_pc[PC_W-1:IDX_W+2], mem_pc[1:0]};

    assign w_rd_idx  = if_pc[IDX_W+1:2];
    assign w_upd_idx = mem_pc[IDX_W+1:2];

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (w_rd_idx),
        .rd_taken  (pred_taken),
        .upd_en    (mem_is_branch),
        .upd_idx   (w_upd_idx),
        .upd_taken (mem_taken)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_mispredict   = mem_is_branch & (mem_taken != mem_pred_taken);
        w_load_use     = ex_memread & (ex_rt != 5'd0) &
                         ((ex_rt == id_rs) | (ex_rt == id_rt));
        redirect       = w_mispredict | mem_is_jump;
        // A jump always goes to its target; a mispredicted branch goes to
        // whichever path it actually resolved to.
        redirect_taken = mem_is_jump | (w_mispredict & mem_taken);
        flush          = redirect ? {FLUSH_STAGES{1'b1}} : {FLUSH_STAGES{1'b0}};
        // The redirect squashes the stalled instructions, so it wins.
        stall_pc       = w_load_use & ~redirect;
        stall_ifid     = w_load_use & ~redirect;
        bubble_idex    = w_load_use & ~redirect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (mem_is_branch) r_branch_cnt  <= sat_inc(r_branch_cnt);
            if (w_mispredict)  r_mispred_cnt <= sat_inc(r_mispred_cnt);
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_ctrl_hazard_unit.sv
// Directed scoreboard bench for ctrl_hazard_unit (4-bit statistics counters).
module tb_ctrl_hazard_unit;

    localparam int PC_W = 32;
    localparam int FS   = 3;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [PC_W-1:0] if_pc;
    logic [4:0]      id_rs, id_rt, ex_rt;
    logic            ex_memread, mem_is_branch, mem_is_jump, mem_taken, mem_pred_taken;
    logic [PC_W-1:0] mem_pc;
    logic            pred_taken, stall_pc, stall_ifid, bubble_idex, redirect, redirect_taken;
    logic [FS-1:0]   flush;
    logic [CW-1:0]   branch_cnt, mispred_cnt;

    ctrl_hazard_unit #(
        .PC_W(PC_W), .BHT_DEPTH(16), .FLUSH_STAGES(FS), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_is_branch(mem_is_branch),
        .mem_is_jump(mem_is_jump), .mem_taken(mem_taken), .mem_pred_taken(mem_pred_taken),
        .mem_pc(mem_pc), .pred_taken(pred_taken), .stall_pc(stall_pc),
        .stall_ifid(stall_ifid), .bubble_idex(bubble_idex), .flush(flush),
        .redirect(redirect), .redirect_taken(redirect_taken),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       p;
        logic       st;
        logic [2:0] fl;
        logic       rd;
        logic       rdt;
        logic [3:0] bc;
        logic [3:0] mc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %0h expected %0h", id, name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per presented vector, away from the active edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("pred_taken",     e.id, 32'(pred_taken),     32'(e.p));
            check("stall_pc",       e.id, 32'(stall_pc),       32'(e.st));
            check("stall_ifid",     e.id, 32'(stall_ifid),     32'(e.st));
            check("bubble_idex",    e.id, 32'(bubble_idex),    32'(e.st));
            check("flush",          e.id, 32'(flush),          32'(e.fl));
            check("redirect",       e.id, 32'(redirect),       32'(e.rd));
            check("redirect_taken", e.id, 32'(redirect_taken), 32'(e.rdt));
            check("branch_cnt",     e.id, 32'(branch_cnt),     32'(e.bc));
            check("mispred_cnt",    e.id, 32'(mispred_cnt),    32'(e.mc));
        end
    end

    // Drive one cycle of inputs plus the hand-computed response; counters shown
    // are the values before this cycle's edge. pulse_rst drops rst_n mid-cycle.
    task automatic vec(input logic [31:0] ipc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] xrt,
                       input logic br, input logic jp, input logic tk, input logic ptk,
                       input logic [31:0] mpc,
                       input logic p, input logic st, input logic [2:0] fl,
                       input logic rd, input logic rdt, input int bc, input int mc,
                       input logic pulse_rst);
        exp_t e;
        @(posedge clk);
        #1;
        if_pc = ipc; id_rs = rs; id_rt = rt; ex_memread = mr; ex_rt = xrt;
        mem_is_branch = br; mem_is_jump = jp; mem_taken = tk; mem_pred_taken = ptk;
        mem_pc = mpc;
        if (pulse_rst) rst_n = 1'b0;
        e.id = vec_id; e.p = p; e.st = st; e.fl = fl; e.rd = rd; e.rdt = rdt;
        e.bc = 4'(bc); e.mc = 4'(mc);
        q.push_back(e);
        vec_id++;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic idle(input logic [31:0] ipc, input logic p, input int bc, input int mc);
        vec(ipc, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
            p, 1'b0, 3'b000, 1'b0, 1'b0, bc, mc, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h40; id_rs = 0; id_rt = 0; ex_memread = 0; ex_rt = 0;
        mem_is_branch = 0; mem_is_jump = 0; mem_taken = 0; mem_pred_taken = 0; mem_pc = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Reset state
        idle(32'h40, 1'b0, 0, 0);
        // Two taken mispredicts at 0x40: WNT->WT->ST; second read sees pre-update WT
        vec(32'h40, 0, 0, 0, 0, 1, 0, 1, 0, 32'h40, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 0, 0, 1'b0);
        vec(32'h40, 0, 0, 0, 0, 1, 0, 1, 0, 32'h40, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 1, 1, 1'b0);
        idle(32'h40, 1'b1, 2, 2);
        // Load-use: match on rs, ex_rt zero, match on rt, no load
        vec(32'h40, 5, 0, 1, 5, 0, 0, 0, 0, 32'h0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2, 2, 1'b0);
        vec(32'h40, 5, 0, 1, 0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2, 2, 1'b0);
        vec(32'h40, 1, 7, 1, 7, 0, 0, 0, 0, 32'h0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2, 2, 1'b0);
        vec(32'h40, 1, 7, 0, 7, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2, 2, 1'b0);
        // Load-use together with a jump: redirect wins
        vec(32'h40, 5, 0, 1, 5, 0, 1, 0, 0, 32'h80, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 2, 2, 1'b0);
        // Jump flagged as branch, correctly predicted not-taken: ST->WT, branch counted
        vec(32'h40, 0, 0, 0, 0, 1, 1, 0, 0, 32'h40, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 2, 2, 1'b0);
        // Four correctly predicted taken at 0x44: WNT->WT->ST->ST->ST
        vec(32'h44, 0, 0, 0, 0, 1, 0, 1, 1, 32'h44, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3, 2, 1'b0);
        vec(32'h44, 0, 0, 0, 0, 1, 0, 1, 1, 32'h44, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 4, 2, 1'b0);
        vec(32'h44, 0, 0, 0, 0, 1, 0, 1, 1, 32'h44, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 5, 2, 1'b0);
        vec(32'h44, 0, 0, 0, 0, 1, 0, 1, 1, 32'h44, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 6, 2, 1'b0);
        // Mispredicted not-taken: ST->WT, redirect to fall-through
        vec(32'h44, 0, 0, 0, 0, 1, 0, 0, 1, 32'h44, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 7, 2, 1'b0);
        idle(32'h44, 1'b1, 8, 3);
        // One more not-taken: WT->WNT proves the entry was WT, not ST
        vec(32'h44, 0, 0, 0, 0, 1, 0, 0, 0, 32'h44, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8, 3, 1'b0);
        idle(32'h44, 1'b0, 9, 3);
        // 20 branch cycles saturate the 4-bit branch counter
        for (int i = 0; i < 20; i++) begin
            vec(32'h48, 0, 0, 0, 0, 1, 0, 0, 0, 32'hC0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0,
                (9 + i > 15) ? 15 : 9 + i, 3, 1'b0);
        end
        idle(32'h48, 1'b0, 15, 3);
        // Mid-cycle reset: counters clear at once, table back to WNT, outputs stay live
        vec(32'h40, 0, 0, 0, 0, 1, 0, 1, 0, 32'h44, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 0, 0, 1'b1);
        // First edge after release applies the update: idx1 WNT->WT
        idle(32'h44, 1'b1, 1, 1);
        idle(32'h40, 1'b0, 1, 1);

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
